seq_lock_fsm_param: RTL

//   Parametrised serial combination lock and sequence detector; next generation of the fixed-pattern lock FSM.

---
 rtl/seq_lock_fsm_param.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_lock_fsm_param.sv
// seq_lock_fsm_param: parametrised serial combination lock / sequence detector.
//   Shifts in accepted bits (data_valid) and pulses unlock one clk after the
//   bit that completes a match against the runtime-loadable code register.
//   Sliding-window (OVERLAP=1) or framed (OVERLAP=0) matching; failed attempts
//   are counted in fail_cnt and saturate at MAX_FAIL.
//   Optional lockout phase enabled by defining SEQ_LOCK_LOCKOUT_EN.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_in, data_valid        serial code bit and its qualifier
//   pattern_load, pattern_in   load a new code (wins over data_valid)
//   unlock                     one-cycle pulse on a match
//   lockout                    high while locked out (0 when feature disabled)
//   fail_cnt                   consecutive failed attempts
module seq_lock_fsm_param #(
  parameter int                   PATTERN_W      = 4,
  parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1011,
  parameter bit                   OVERLAP        = 1'b1,
  parameter int                   MAX_FAIL       = 3,
  parameter int                   LOCKOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            data_in,
  input  logic                            data_valid,
  input  logic                            pattern_load,
  input  logic [PATTERN_W-1:0]            pattern_in,
  output logic                            unlock,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FC_W   = $clog2(MAX_FAIL + 1);
  localparam int FILL_W = $clog2(PATTERN_W);
  localparam int BS_W   = $clog2(2 * PATTERN_W + 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_LOCKOUT} state_t;

  state_t                state_q, state_d;
  logic [PATTERN_W-1:0]  window_q, window_d;
  logic [PATTERN_W-1:0]  code_q, code_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [BS_W-1:0]       bits_since_q, bits_since_d;
  logic [FC_W-1:0]       fail_cnt_q, fail_cnt_d;
  logic                  unlock_q, unlock_d;

  logic [PATTERN_W-1:0]  new_win;
  logic                  hit;
  logic                  last_fill;
  logic                  full;
  logic                  fail_hit;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam int LC_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [LC_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                  lockout_q, lockout_d;
`endif

  assign new_win   = {window_q[PATTERN_W-2:0], data_in};
  assign hit       = (new_win == code_q);
  // The bit arriving at fill==PATTERN_W-1 completes the window and is judged on this edge.
  assign last_fill = (state_q == S_FILL) && (fill_q == FILL_W'(PATTERN_W - 1));
  assign full      = last_fill || (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    code_d       = code_q;
    fill_d       = fill_q;
    bits_since_d = bits_since_q;
    fail_cnt_d   = fail_cnt_q;
    unlock_d     = 1'b0;
    fail_hit     = 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
    lock_cnt_d   = lock_cnt_q;

    if (state_q == S_LOCKOUT) begin
      // Count held at LOCKOUT_CYCLES-1 on entry, so lockout spans exactly LOCKOUT_CYCLES clks.
      if (lock_cnt_q == '0) begin
        state_d      = S_FILL;
        fill_d       = '0;
        fail_cnt_d   = '0;
        bits_since_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q - 1'b1;
      end
    end else
`endif
    if (pattern_load) begin
      code_d       = pattern_in;
      fill_d       = '0;
      fail_cnt_d   = '0;
      bits_since_d = '0;
      state_d      = S_FILL;
    end else if (data_valid) begin
      window_d = new_win;
      if ((state_q == S_FILL) && !last_fill) begin
        fill_d = fill_q + 1'b1;
      end
      if (OVERLAP) begin
        if (full) begin
          state_d = S_RUN;
        end
        if (full && hit) begin
          unlock_d     = 1'b1;
          fail_cnt_d   = '0;
          bits_since_d = '0;
        end else if (bits_since_q == BS_W'(2 * PATTERN_W - 1)) begin
          // Two code lengths of accepted bits without a match is one failed attempt.
          bits_since_d = '0;
          fail_hit     = 1'b1;
        end else begin
          bits_since_d = bits_since_q + 1'b1;
        end
      end else if (last_fill) begin
        // Frame closes: restart filling so frames never share bits.
        fill_d  = '0;
        state_d = S_FILL;
        if (hit) begin
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
        end else begin
          fail_hit = 1'b1;
        end
      end
    end

    if (fail_hit) begin
      if (fail_cnt_q != FC_W'(MAX_FAIL)) begin
        fail_cnt_d = fail_cnt_q + 1'b1;
      end
`ifdef SEQ_LOCK_LOCKOUT_EN
      if (fail_cnt_q == FC_W'(MAX_FAIL - 1)) begin
        state_d    = S_LOCKOUT;
        lock_cnt_d = LC_W'(LOCKOUT_CYCLES - 1);
      end
`endif
    end

`ifdef SEQ_LOCK_LOCKOUT_EN
    lockout_d = (state_d == S_LOCKOUT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      window_q     <= '0;
      code_q       <= PATTERN;
      fill_q       <= '0;
      bits_since_q <= '0;
      fail_cnt_q   <= '0;
      unlock_q     <= 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
      lock_cnt_q   <= '0;
      lockout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      code_q       <= code_d;
      fill_q       <= fill_d;
      bits_since_q <= bits_since_d;
      fail_cnt_q   <= fail_cnt_d;
      unlock_q     <= unlock_d;
`ifdef SEQ_LOCK_LOCKOUT_EN
      lock_cnt_q   <= lock_cnt_d;
      lockout_q    <= lockout_d;
`endif
    end
  end

  assign unlock   = unlock_q;
  assign fail_cnt = fail_cnt_q;
`ifdef SEQ_LOCK_LOCKOUT_EN
  assign lockout  = lockout_q;
`else
  assign lockout  = 1'b0;
`endif

endmodule
